// File: rtl/dot_acc.sv
// dot_acc: sequences operand pairs through an external sequential 16x8
// multiplier and accumulates the products into a sum that cannot overflow.
// Pairs arrive over a valid/ready handshake. The final sum is published on
// y_bo together with a one-cycle done_o pulse.
module dot_acc #(
  parameter int LEN_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_bi,
  input  logic [15:0]          a_bi,
  input  logic [7:0]           b_bi,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  output logic [15:0]          mult_a_bo,
  output logic [7:0]           mult_b_bo,
  output logic                 mult_start_o,
  input  logic                 mult_busy_i,
  input  logic [23:0]          mult_y_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [24+LEN_W-1:0]  y_bo
);

  localparam int SUM_W = 24 + LEN_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    ACC
  } StateT;

  StateT              r_state;
  StateT              w_nextState;
  logic [LEN_W-1:0]   r_count;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W-1:0]   r_y;
  logic               r_done;
  logic [15:0]        r_multA;
  logic [7:0]         r_multB;
  logic [SUM_W-1:0]   w_accSum;
  logic               w_lastPair;

  // The product is zero-extended so the sum carries the extra LEN_W bits.
  assign w_accSum   = r_sum + {{LEN_W{1'b0}}, mult_y_bi};
  assign w_lastPair = (r_count == LEN_W'(1));

  assign mult_a_bo = r_multA;
  assign mult_b_bo = r_multB;
  assign done_o    = r_done;
  assign y_bo      = r_y;

  // State register; reset returns the sequencer to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and state-decoded handshake/strobe outputs.
  always_comb begin
    w_nextState  = r_state;
    op_ready_o   = 1'b0;
    mult_start_o = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i && (len_bi != '0)) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        mult_start_o = 1'b1;
        w_nextState  = WAIT_HI;
      end
      WAIT_HI: begin
        if (mult_busy_i) begin
          w_nextState = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!mult_busy_i) begin
          w_nextState = ACC;
        end
      end
      ACC: begin
        w_nextState = w_lastPair ? IDLE : FETCH;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: run setup, operand capture, accumulation and result publication.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_sum   <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_multA <= '0;
      r_multB <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (len_bi != '0) begin
              r_count <= len_bi;
              r_sum   <= '0;
            end else begin
              r_y    <= '0;
              r_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (op_valid_i) begin
            r_multA <= a_bi;
            r_multB <= b_bi;
          end
        end
        ACC: begin
          r_sum   <= w_accSum;
          r_count <= r_count - LEN_W'(1);
          if (w_lastPair) begin
            r_y    <= w_accSum;
            r_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_acc.sv
// tb_dot_acc: directed and randomized runs of dot_acc against a behavioural
// sequential multiplier and a sum-of-products reference computed per run.
module tb_dot_acc;

  localparam int LEN_W = 4;
  localparam int Y_W   = 24 + LEN_W;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [LEN_W-1:0] len_bi;
  logic [15:0]      a_bi;
  logic [7:0]       b_bi;
  logic             op_valid_i;
  logic             op_ready_o;
  logic [15:0]      mult_a_bo;
  logic [7:0]       mult_b_bo;
  logic             mult_start_o;
  logic             mult_busy_i = 1'b0;
  logic [23:0]      mult_y_bi = '0;
  logic             busy_o;
  logic             done_o;
  logic [Y_W-1:0]   y_bo;

  int testCount = 0;
  int failCount = 0;
  int cycleCnt  = 0;
  int doneCnt   = 0;
  int doneCycle = -1;
  int startCnt  = 0;
  int multLat   = 8;
  int multLeft  = 0;
  int lastY     = 0;

  dot_acc #(.LEN_W(LEN_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_bi       (len_bi),
    .a_bi         (a_bi),
    .b_bi         (b_bi),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .mult_a_bo    (mult_a_bo),
    .mult_b_bo    (mult_b_bo),
    .mult_start_o (mult_start_o),
    .mult_busy_i  (mult_busy_i),
    .mult_y_bi    (mult_y_bi),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .y_bo         (y_bo)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Sequential multiplier: busy for multLat cycles after the strobe, garbage on
  // the product while busy, true product of the held operands once it drops.
  always @(posedge clk_i) begin
    if (rst_i) begin
      mult_busy_i <= 1'b0;
      multLeft    <= 0;
    end else if (mult_start_o) begin
      mult_busy_i <= 1'b1;
      multLeft    <= multLat - 1;
      mult_y_bi   <= 24'($urandom);
    end else if (mult_busy_i) begin
      if (multLeft == 0) begin
        mult_busy_i <= 1'b0;
        mult_y_bi   <= 24'(mult_a_bo) * 24'(mult_b_bo);
      end else begin
        multLeft <= multLeft - 1;
      end
    end
  end

  // Cycle counter plus done/strobe event counters, sampled just after each edge.
  always @(posedge clk_i) begin
    #1;
    cycleCnt <= cycleCnt + 1;
    if (done_o === 1'b1) begin
      doneCnt   <= doneCnt + 1;
      doneCycle <= cycleCnt + 1;
    end
    if (mult_start_o === 1'b1) begin
      startCnt <= startCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic feedPair(input int a, input int b, input int gap);
    int guard;
    int startsBefore;
    guard = 0;
    while (op_ready_o !== 1'b1 && guard < 300) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("readyTimeout", 32'(guard < 300), 1);
    startsBefore = startCnt;
    for (int g = 0; g < gap; g++) begin
      op_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("readyHeld", 32'(op_ready_o), 1);
    end
    if (gap > 0) checkOutput("noEarlyStrobe", startCnt, startsBefore);
    a_bi       = 16'(a);
    b_bi       = 8'(b);
    op_valid_i = 1'b1;
    @(negedge clk_i);
    op_valid_i = 1'b0;
    a_bi       = 16'($urandom);
    b_bi       = 8'($urandom);
  endtask

  task automatic waitDone(input int prevDone);
    int guard;
    guard = 0;
    while (doneCnt == prevDone && guard < 500) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("doneTimeout", 32'(guard < 500), 1);
  endtask

  // One complete run; the expected result is the plain sum of a*b over the pairs sent.
  task automatic applyStimulus(input int len, input bit useFixed, input int fixA, input int fixB,
                               input int gapMin, input int gapMax, input bit midStart,
                               output int startCycle);
    int expY;
    int prevDone;
    int a;
    int b;
    int gap;
    prevDone   = doneCnt;
    expY       = 0;
    start_i    = 1'b1;
    len_bi     = LEN_W'(len);
    startCycle = cycleCnt;
    @(negedge clk_i);
    start_i = 1'b0;
    len_bi  = LEN_W'($urandom);
    for (int i = 0; i < len; i++) begin
      a   = useFixed ? fixA : int'($urandom_range(65535, 0));
      b   = useFixed ? fixB : int'($urandom_range(255, 0));
      gap = int'($urandom_range(gapMax, gapMin));
      feedPair(a, b, gap);
      expY += a * b;
      if (midStart && i == 0) begin
        start_i = 1'b1;
        len_bi  = LEN_W'(1);
        @(negedge clk_i);
        start_i = 1'b0;
        checkOutput("yHeldMidRun", 32'(y_bo), lastY);
      end
    end
    waitDone(prevDone);
    repeat (3) @(negedge clk_i);
    checkOutput("yResult", 32'(y_bo), expY);
    checkOutput("donePulses", doneCnt - prevDone, 1);
    checkOutput("busyIdle", 32'(busy_o), 0);
    lastY = expY;
  endtask

  initial begin
    int sc;
    int prevDone;
    int startsBefore;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    len_bi     = '0;
    a_bi       = '0;
    b_bi       = '0;
    op_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rstY", 32'(y_bo), 0);
    checkOutput("rstDone", 32'(done_o), 0);
    checkOutput("rstBusy", 32'(busy_o), 0);
    checkOutput("rstReady", 32'(op_ready_o), 0);
    checkOutput("rstStrobe", 32'(mult_start_o), 0);
    checkOutput("rstMultA", 32'(mult_a_bo), 0);
    checkOutput("rstMultB", 32'(mult_b_bo), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    multLat = 8;
    applyStimulus(1, 1'b1, 3, 5, 0, 0, 1'b0, sc);
    checkOutput("doneLatency", doneCycle - sc, 13);

    applyStimulus(3, 1'b1, 65535, 255, 0, 0, 1'b0, sc);

    multLat = 3;
    applyStimulus(2, 1'b0, 0, 0, 5, 5, 1'b0, sc);

    multLat = 5;
    applyStimulus(4, 1'b0, 0, 0, 0, 2, 1'b1, sc);

    startsBefore = startCnt;
    applyStimulus(0, 1'b0, 0, 0, 0, 0, 1'b0, sc);
    checkOutput("doneLatencyLen0", doneCycle - sc, 1);
    checkOutput("noStrobeLen0", startCnt, startsBefore);

    for (int r = 0; r < 6; r++) begin
      multLat = int'($urandom_range(8, 1));
      applyStimulus(int'($urandom_range(15, 1)), 1'b0, 0, 0, 0, 3, r[0], sc);
    end

    multLat = 2;
    applyStimulus(15, 1'b1, 65535, 255, 0, 1, 1'b0, sc);

    multLat  = 8;
    prevDone = doneCnt;
    start_i  = 1'b1;
    len_bi   = LEN_W'(3);
    @(negedge clk_i);
    start_i = 1'b0;
    feedPair(1234, 56, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("busyBeforeAbort", 32'(busy_o), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abortY", 32'(y_bo), 0);
    checkOutput("abortDone", 32'(done_o), 0);
    checkOutput("abortBusy", 32'(busy_o), 0);
    checkOutput("abortReady", 32'(op_ready_o), 0);
    checkOutput("abortStrobe", 32'(mult_start_o), 0);
    checkOutput("abortMultA", 32'(mult_a_bo), 0);
    checkOutput("abortMultB", 32'(mult_b_bo), 0);
    rst_i = 1'b0;
    lastY = 0;
    repeat (30) @(negedge clk_i);
    checkOutput("noDoneAfterAbort", doneCnt, prevDone);
    checkOutput("idleAfterAbort", 32'(busy_o), 0);

    multLat = 4;
    applyStimulus(5, 1'b0, 0, 0, 0, 2, 1'b1, sc);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
